dmem_rmw_ctrl: RTL and testbench

- Memory-side responder for CPU data accesses in the MIPS core.
- Accepts one request at a time: word, half, byte, left (LWL/SWL) or right (LWR/SWR), load or store.
- Drives a word-only synchronous data RAM. Sub-word and partial stores are done as sequenced read-modify-write.
- Returns load data to the CPU. Byte order is big-endian: byte offset 0 is bits [31:24].

---
 rtl/dmem_rmw_ctrl.sv | 106 ++++++++++
 tb/tb_dmem_rmw_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl: CPU data-access responder driving a word-only RAM, with read-modify-write for partial stores.
module dmem_rmw_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t            state, state_nx;
    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        type_q;
    logic              we_q;
    logic [31:0]       wdata_q, rbuf, ld_word, st_word;
    logic [4:0]        sh, rsh;
    logic              accept, bad, unused_addr;

    assign sh          = {addr_q[1:0], 3'b000};
    assign rsh         = 5'd24 - sh;
    assign accept      = req_valid && req_ready;
    assign bad         = req_type > 4'd4 || (req_type == 4'd0 && req_addr[1:0] != 2'b00) ||
                         (req_type == 4'd1 && req_addr[0]);
    assign req_ready   = state == IDLE;
    assign resp_valid  = state == RESP;
    // Strobes decode straight from state so an async reset drops them at once.
    assign mem_en      = state == RD || state == WR;
    assign mem_we      = state == WR;
    assign mem_addr    = addr_q[ADDR_W+1:2];
    assign mem_wdata   = mem_we ? st_word : '0;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // Big-endian lanes: shifting left by 8k brings lane k to the top byte.
    always_comb begin
        case (type_q)
            3'd1:    ld_word = {16'h0, addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16]};
            3'd2:    ld_word = (mem_rdata << sh) >> 24;
            3'd3:    ld_word = (mem_rdata << sh) | (wdata_q & ~(32'hFFFFFFFF << sh));
            3'd4:    ld_word = (mem_rdata >> rsh) | (wdata_q & ~(32'hFFFFFFFF >> rsh));
            default: ld_word = mem_rdata;
        endcase
    end

    always_comb begin
        case (type_q)
            3'd1:    st_word = addr_q[1] ? {rbuf[31:16], wdata_q[15:0]} : {wdata_q[15:0], rbuf[15:0]};
            3'd2:    st_word = (rbuf & ~(32'hFF000000 >> sh)) | ({4{wdata_q[7:0]}} & (32'hFF000000 >> sh));
            3'd3:    st_word = (rbuf & ~(32'hFFFFFFFF >> sh)) | (wdata_q >> sh);
            3'd4:    st_word = (rbuf & ((32'hFFFFFFFF >> sh) >> 8)) | (wdata_q << rsh);
            default: st_word = wdata_q;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bad ? RESP : (req_we && req_type == 4'd0) ? WR : RD;
            RD:      state_nx = WAIT;
            WAIT:    state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            type_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rbuf       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q     <= req_addr[ADDR_W+1:0];
                type_q     <= req_type[2:0];
                we_q       <= req_we;
                wdata_q    <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= bad;
            end
            if (state == WAIT) begin
                rbuf <= mem_rdata;
                if (!we_q) resp_rdata <= ld_word;
            end
        end
    end
endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// tb_dmem_rmw_ctrl: randomized scoreboard bench for dmem_rmw_ctrl against a byte-array memory model.
module tb_dmem_rmw_ctrl;
    localparam int AW = 10;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nen;
        int          nwr;
    } exp_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [3:0]    req_type = '0;
    logic [31:0]   req_addr = '0, req_wdata = '0;
    logic          req_ready, resp_valid, resp_err, mem_en, mem_we;
    logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr, cur_wa;

    logic [31:0] ram  [0:1023];
    logic [7:0]  rmem [0:4095];
    exp_t        exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, acc_cyc = 0, en_cnt = 0, wr_cnt = 0, addr_bad = 0;
    bit          seen = 0, stall = 0, force_rdy = 0;
    logic [31:0] held;

    always #5 clk = ~clk;

    dmem_rmw_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rbyte(input logic [31:0] r, input int j);
        return 8'(r >> (24 - 8 * j));
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {rmem[4*w], rmem[4*w+1], rmem[4*w+2], rmem[4*w+3]};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        ram[w] = v;
        for (int i = 0; i < 4; i++) rmem[4*w+i] = rbyte(v, i);
    endtask

    // Reference: memory as big-endian bytes; byte 0 of a register is its most significant byte.
    task automatic model(input logic we, input logic [3:0] t, input logic [31:0] a, input logic [31:0] r);
        exp_t        e;
        int          k = int'(a[1:0]);
        int          b = int'({a[11:2], 2'b00});
        logic [31:0] res = '0;
        e.err = t > 4 || (t == 0 && k != 0) || (t == 1 && a[0]);
        e.rdata = '0;
        e.nwr = 0;
        if (e.err) begin
            e.lat = 1;
            e.nen = 0;
        end else if (!we) begin
            for (int j = 0; j < 4; j++) begin
                logic [7:0] by;
                case (t)
                    4'd0:    by = rmem[b+j];
                    4'd1:    by = (j >= 2) ? rmem[b+k+j-2] : 8'h00;
                    4'd2:    by = (j == 3) ? rmem[b+k] : 8'h00;
                    4'd3:    by = (j <= 3 - k) ? rmem[b+k+j] : rbyte(r, j);
                    default: by = (j >= 3 - k) ? rmem[b+j-3+k] : rbyte(r, j);
                endcase
                res = (res << 8) | {24'h0, by};
            end
            e.rdata = res;
            e.lat = 3;
            e.nen = 1;
        end else begin
            case (t)
                4'd0: for (int i = 0; i < 4; i++) rmem[b+i] = rbyte(r, i);
                4'd1: begin rmem[b+k] = r[15:8]; rmem[b+k+1] = r[7:0]; end
                4'd2: rmem[b+k] = r[7:0];
                4'd3: for (int i = k; i < 4; i++) rmem[b+i] = rbyte(r, i - k);
                default: for (int i = 0; i <= k; i++) rmem[b+i] = rbyte(r, i + 3 - k);
            endcase
            e.lat = (t == 0) ? 2 : 4;
            e.nen = (t == 0) ? 1 : 2;
            e.nwr = 1;
        end
        exp_q.push_back(e);
    endtask

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end

    // Monitor: samples on the falling edge, away from state updates.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n && req_valid && req_ready) begin
            acc_cyc = cyc;
            en_cnt = 0;
            wr_cnt = 0;
            addr_bad = 0;
            cur_wa = req_addr[AW+1:2];
        end else if (mem_en) begin
            en_cnt++;
            if (mem_we) wr_cnt++;
            if (mem_addr !== cur_wa) addr_bad++;
        end
        if (rst_n && resp_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) chk("unexpected_resp", 32'(exp_q.size()), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("mem_en_cycles", en_cnt, e.nen);
                    chk("mem_we_cycles", wr_cnt, e.nwr);
                    chk("mem_addr_stable", addr_bad, 0);
                end
                seen = 1;
                held = resp_rdata;
            end else begin
                chk("rdata_hold", resp_rdata, held);
                chk("req_ready_in_resp", {31'h0, req_ready}, 0);
            end
            if (resp_ready) seen = 0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        resp_ready = force_rdy ? 1'b1 : stall ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    task automatic do_req(input logic we, input logic [3:0] t, input logic [31:0] a, input logic [31:0] r);
        int n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            chk("req_ready_timeout", {31'h0, req_ready}, 1);
            return;
        end
        model(we, t, a, r);
        req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = r;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 300) begin @(posedge clk); #1; n++; end
        if (exp_q.size() != 0 || !req_ready) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 1);
        chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 0);
        chk({tag, "_resp_err"}, {31'h0, resp_err}, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_mem_en"}, {31'h0, mem_en}, 0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 0);
        chk({tag, "_mem_addr"}, {22'h0, mem_addr}, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        for (int w = 0; w < 1024; w++) set_word(w, $urandom);
        set_word(16, 32'h11223344);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        force_rdy = 1;

        do_req(0, 4'd2, 32'h41, 32'h0);
        do_req(0, 4'd3, 32'h41, 32'hAABBCCDD);
        do_req(1, 4'd1, 32'h42, 32'h0000ABCD);
        wait_idle();
        chk("sh_ram_word", ram[16], 32'h1122ABCD);
        do_req(1, 4'd0, 32'h40, 32'h11223344);
        do_req(1, 4'd4, 32'h40, 32'hAABBCCDD);
        wait_idle();
        chk("swr_ram_word", ram[16], 32'hDD223344);

        for (int k = 0; k < 4; k++)
            for (int t = 3; t <= 4; t++)
                for (int we = 0; we < 2; we++) begin
                    do_req(we[0], 4'(t), 32'h80 + k, $urandom);
                    wait_idle();
                    chk("sweep_ram_word", ram[32], model_word(32));
                end

        do_req(0, 4'd0, 32'h42, 32'h0);
        do_req(1, 4'd1, 32'h41, 32'h1234);
        do_req(0, 4'd7, 32'h40, 32'h0);
        do_req(1, 4'd15, 32'h40, 32'hFFFFFFFF);
        wait_idle();

        force_rdy = 0;
        stall = 1;
        do_req(0, 4'd2, 32'h43, 32'h0);
        n = 0;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("stall_resp_seen", {31'h0, resp_valid}, 1);
        repeat (5) @(posedge clk);
        #1;
        stall = 0;
        wait_idle();

        force_rdy = 1;
        do_req(1, 4'd0, 32'h100, 32'hCAFEF00D);
        do_req(1, 4'd0, 32'h104, 32'h12345678);
        wait_idle();
        chk("sw_b2b_word0", ram[64], 32'hCAFEF00D);
        chk("sw_b2b_word1", ram[65], 32'h12345678);

        // Byte store aborted by reset while its write strobe is up.
        req_valid = 1'b1; req_we = 1'b1; req_type = 4'd2; req_addr = 32'h45; req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_in_wr", {31'h0, mem_we}, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_ram_word", ram[17], model_word(17));

        force_rdy = 0;
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  t;
            logic [31:0] a;
            t = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                if (t == 4'd0) a[1:0] = 2'b00;
                if (t == 4'd1) a[0] = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            do_req(1'($urandom_range(0, 1)), t, a, $urandom);
        end
        wait_idle();
        for (int w = 0; w < 128; w++) chk("final_ram_word", ram[w], model_word(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
